sys_ctrl_boot_seq: RTL

- Boot sequencer; the initiator on the SYS_CTRL register interface (base 0x0000_2000).
- After `start_i`, it performs a fixed sequence of single-cycle register transactions:
  - programs the three PLLs and polls each for lock;
  - loads both core boot addresses;
  - enables clocks and releases resets for the E and P cores.
- Sits between the always-on boot logic and the sys_ctrl register block; an external mux hands the register port to the CPU bus once `busy_o` falls.

---
 rtl/hyper_titan_pkg.sv | 38 +++
 rtl/sys_ctrl_boot_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hyper_titan_pkg.sv
// Shared hyper_titan definitions: sys_ctrl register offsets and boot sequencer types.
package hyper_titan_pkg;

  localparam logic [31:0] SYS_CTRL_BASE_ADDR          = 32'h0000_2000;

  localparam logic [31:0] REG_OFFSET_PLL_CFG_E_CORE   = 32'h0000_0000;
  localparam logic [31:0] REG_OFFSET_PLL_CFG_P_CORE   = 32'h0000_0004;
  localparam logic [31:0] REG_OFFSET_PLL_CFG_SYS_LINK = 32'h0000_0008;
  localparam logic [31:0] REG_OFFSET_BOOT_ADDR_E_CORE = 32'h0000_000C;
  localparam logic [31:0] REG_OFFSET_BOOT_ADDR_P_CORE = 32'h0000_0010;
  localparam logic [31:0] REG_OFFSET_E_CORE_CLK_RST   = 32'h0000_0014;
  localparam logic [31:0] REG_OFFSET_P_CORE_CLK_RST   = 32'h0000_0018;

  localparam int BOOT_SEQ_NUM_STEPS = 12;
  localparam int PLL_LOCK_BIT       = 16;

  typedef enum logic [2:0] {
    BOOT_SEQ_IDLE  = 3'd0,
    BOOT_SEQ_XFER  = 3'd1,
    BOOT_SEQ_GAP   = 3'd2,
    BOOT_SEQ_DONE  = 3'd3,
    BOOT_SEQ_ERROR = 3'd4
  } boot_seq_state_e;

  typedef enum logic [1:0] {
    BOOT_SEQ_ERR_NONE    = 2'b00,
    BOOT_SEQ_ERR_WR      = 2'b01,
    BOOT_SEQ_ERR_RD      = 2'b10,
    BOOT_SEQ_ERR_TIMEOUT = 2'b11
  } boot_seq_err_e;

  typedef struct packed {
    logic        is_poll;
    logic [31:0] addr;
    logic [31:0] data;
  } boot_seq_step_t;

endpackage

// File: rtl/sys_ctrl_boot_seq.sv
// Boot sequencer: walks a fixed table of sys_ctrl register writes and PLL lock polls
// after start, then reports done or the failing step and cause.
module sys_ctrl_boot_seq
  import hyper_titan_pkg::*;
#(
  parameter logic [3:0]  E_REF_DIV  = 4'd1,
  parameter logic [11:0] E_FB_DIV   = 12'd100,
  parameter logic [3:0]  P_REF_DIV  = 4'd1,
  parameter logic [11:0] P_FB_DIV   = 12'd150,
  parameter logic [3:0]  SL_REF_DIV = 4'd1,
  parameter logic [11:0] SL_FB_DIV  = 12'd50,
  parameter int unsigned MAX_POLLS  = 64,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic        arst_ni,
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] boot_addr_e_core_i,
  input  logic [31:0] boot_addr_p_core_i,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [1:0]  mem_wresp_i,
  output logic        mem_re_o,
  output logic [31:0] mem_raddr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  err_step_o,
  output logic [1:0]  err_code_o
);

  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  localparam logic [2:0] ST_IDLE  = BOOT_SEQ_IDLE;
  localparam logic [2:0] ST_XFER  = BOOT_SEQ_XFER;
  localparam logic [2:0] ST_GAP   = BOOT_SEQ_GAP;
  localparam logic [2:0] ST_DONE  = BOOT_SEQ_DONE;
  localparam logic [2:0] ST_ERROR = BOOT_SEQ_ERROR;

  localparam logic [3:0] LAST_STEP = 4'(BOOT_SEQ_NUM_STEPS - 1);

  logic [2:0]        state_q;
  logic [3:0]        step_q;
  logic [POLL_W-1:0] poll_cnt_q;
  logic [POLL_W-1:0] poll_next;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [31:0]       boot_addr_e_q;
  logic [31:0]       boot_addr_p_q;
  logic [3:0]        err_step_q;
  logic [1:0]        err_code_q;
  boot_seq_step_t    cur;
  logic              issuing;
  logic              unused_rdata;

  function automatic boot_seq_step_t step_entry(input logic [3:0]  step,
                                                input logic [31:0] addr_e,
                                                input logic [31:0] addr_p);
    boot_seq_step_t e;
    e = '0;
    case (step)
      4'd0:  begin e.addr = REG_OFFSET_PLL_CFG_E_CORE;   e.data = {16'b0, E_FB_DIV, E_REF_DIV};   end
      4'd1:  begin e.addr = REG_OFFSET_PLL_CFG_P_CORE;   e.data = {16'b0, P_FB_DIV, P_REF_DIV};   end
      4'd2:  begin e.addr = REG_OFFSET_PLL_CFG_SYS_LINK; e.data = {16'b0, SL_FB_DIV, SL_REF_DIV}; end
      4'd3:  begin e.is_poll = 1'b1; e.addr = REG_OFFSET_PLL_CFG_E_CORE;   end
      4'd4:  begin e.is_poll = 1'b1; e.addr = REG_OFFSET_PLL_CFG_P_CORE;   end
      4'd5:  begin e.is_poll = 1'b1; e.addr = REG_OFFSET_PLL_CFG_SYS_LINK; end
      4'd6:  begin e.addr = REG_OFFSET_BOOT_ADDR_E_CORE; e.data = addr_e;   end
      4'd7:  begin e.addr = REG_OFFSET_BOOT_ADDR_P_CORE; e.data = addr_p;   end
      4'd8:  begin e.addr = REG_OFFSET_E_CORE_CLK_RST;   e.data = 32'h1;    end
      4'd9:  begin e.addr = REG_OFFSET_E_CORE_CLK_RST;   e.data = 32'h3;    end
      4'd10: begin e.addr = REG_OFFSET_P_CORE_CLK_RST;   e.data = 32'h1;    end
      4'd11: begin e.addr = REG_OFFSET_P_CORE_CLK_RST;   e.data = 32'h3;    end
      default: e = '0;
    endcase
    return e;
  endfunction

  assign cur       = step_entry(step_q, boot_addr_e_q, boot_addr_p_q);
  assign issuing   = (state_q == ST_XFER);
  assign poll_next = poll_cnt_q + 1'b1;

  // Only the lock bit of the poll read matters; the rest of the word is don't-care.
  assign unused_rdata = ^(mem_rdata_i & ~(32'd1 << PLL_LOCK_BIT));

  assign mem_we_o    = issuing && !cur.is_poll;
  assign mem_re_o    = issuing && cur.is_poll;
  assign mem_waddr_o = mem_we_o ? cur.addr : 32'h0;
  assign mem_wdata_o = mem_we_o ? cur.data : 32'h0;
  assign mem_wstrb_o = mem_we_o ? 4'hF : 4'h0;
  assign mem_raddr_o = mem_re_o ? cur.addr : 32'h0;

  assign busy_o     = (state_q == ST_XFER) || (state_q == ST_GAP);
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = (state_q == ST_ERROR);
  assign err_step_o = err_step_q;
  assign err_code_o = err_code_q;

  // Each XFER cycle resolves its transaction immediately from the same-cycle response.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q       <= ST_IDLE;
      step_q        <= 4'd0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      boot_addr_e_q <= 32'h0;
      boot_addr_p_q <= 32'h0;
      err_step_q    <= 4'd0;
      err_code_q    <= BOOT_SEQ_ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            boot_addr_e_q <= boot_addr_e_core_i;
            boot_addr_p_q <= boot_addr_p_core_i;
            err_step_q    <= 4'd0;
            err_code_q    <= BOOT_SEQ_ERR_NONE;
            step_q        <= 4'd0;
            poll_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            state_q       <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!cur.is_poll) begin
            if (mem_wresp_i == 2'b00) begin
              if (step_q == LAST_STEP) state_q <= ST_DONE;
              else                     step_q  <= step_q + 4'd1;
            end else begin
              state_q    <= ST_ERROR;
              err_step_q <= step_q;
              err_code_q <= BOOT_SEQ_ERR_WR;
            end
          end else if (mem_rresp_i != 2'b00) begin
            state_q    <= ST_ERROR;
            err_step_q <= step_q;
            err_code_q <= BOOT_SEQ_ERR_RD;
          end else if (mem_rdata_i[PLL_LOCK_BIT]) begin
            poll_cnt_q <= '0;
            if (step_q == LAST_STEP) state_q <= ST_DONE;
            else                     step_q  <= step_q + 4'd1;
          end else begin
            poll_cnt_q <= poll_next;
            if (poll_next == POLL_W'(MAX_POLLS)) begin
              state_q    <= ST_ERROR;
              err_step_q <= step_q;
              err_code_q <= BOOT_SEQ_ERR_TIMEOUT;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) state_q   <= ST_XFER;
          else                                   gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
